// File: rtl/tpu_pkg.sv
// Shared constants, opcodes and FSM state type for the tiny TPU command block.
package tpu_pkg;

    localparam int TPU_WH     = 16;
    localparam int TPU_DW     = 8;
    localparam int TPU_MAX_WH = 128;

    localparam int DIM_W  = 4;
    localparam int ADDR_W = 8;
    localparam int TILE_W = 3;

    localparam logic [2:0] OP_CLEAR  = 3'b111;
    localparam logic [2:0] OP_WR_IN  = 3'b001;
    localparam logic [2:0] OP_WR_W   = 3'b010;
    localparam logic [2:0] OP_LOAD_W = 3'b011;
    localparam logic [2:0] OP_MATMUL = 3'b100;
    localparam logic [2:0] OP_RD_OUT = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Commands that spend dim_1+1 cycles in BUSY; everything else finishes at k=1.
    function automatic logic is_streaming(input logic [2:0] op);
        return (op == OP_WR_IN) || (op == OP_WR_W) || (op == OP_LOAD_W) ||
               (op == OP_MATMUL) || (op == OP_RD_OUT);
    endfunction

endpackage

// File: rtl/tpu_mac_row.sv
// Combinational row-vector x matrix product, wrapping mod 2^DATA_WIDTH, with active-size masking.
module tpu_mac_row
    import tpu_pkg::*;
#(
    parameter int WIDTH_HEIGHT = TPU_WH,
    parameter int DATA_WIDTH   = TPU_DW
) (
    input  logic [WIDTH_HEIGHT*DATA_WIDTH-1:0]              x_row,
    input  logic [WIDTH_HEIGHT*WIDTH_HEIGHT*DATA_WIDTH-1:0] weights,
    input  logic [DIM_W-1:0]                                dim_2,
    input  logic [DIM_W-1:0]                                dim_3,
    output logic [WIDTH_HEIGHT*DATA_WIDTH-1:0]              y_row
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH_HEIGHT; gi++) begin : g_col
            logic [DATA_WIDTH-1:0] sum;

            // Weight row j, column gi sits at element (j*WIDTH_HEIGHT + gi).
            always_comb begin
                sum = '0;
                for (int j = 0; j < WIDTH_HEIGHT; j++) begin
                    if (DIM_W'(j) <= dim_2) begin
                        sum = sum + x_row[j*DATA_WIDTH +: DATA_WIDTH] *
                                    weights[(j*WIDTH_HEIGHT + gi)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            assign y_row[gi*DATA_WIDTH +: DATA_WIDTH] = (DIM_W'(gi) <= dim_3) ? sum : '0;
        end
    endgenerate

endmodule

// File: rtl/tpu_top.sv
// Tiny TPU command block: host-fed input/weight memories, weight register tile,
// one MAC row per cycle and a tiled accumulator memory with per-row valid bits.
module tpu_top
    import tpu_pkg::*;
#(
    parameter int WIDTH_HEIGHT = TPU_WH,
    parameter int DATA_WIDTH   = TPU_DW,
    parameter int MAX_MAT_WH   = TPU_MAX_WH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [2:0]                         opcode,
    input  logic [DIM_W-1:0]                   dim_1,
    input  logic [DIM_W-1:0]                   dim_2,
    input  logic [DIM_W-1:0]                   dim_3,
    input  logic [ADDR_W-1:0]                  addr_1,
    input  logic [TILE_W-1:0]                  accum_table_submat_row_in,
    input  logic [TILE_W-1:0]                  accum_table_submat_col_in,
    output logic                               done,
    output logic                               fifo_ready,
    input  logic [WIDTH_HEIGHT*DATA_WIDTH-1:0] inputMem_wr_data,
    input  logic [WIDTH_HEIGHT*DATA_WIDTH-1:0] weightMem_wr_data,
    output logic [WIDTH_HEIGHT*DATA_WIDTH-1:0] outputMem_rd_data
);

    localparam int ROW_W    = WIDTH_HEIGHT * DATA_WIDTH;
    localparam int TILES    = MAX_MAT_WH / WIDTH_HEIGHT;
    localparam int ACC_ROWS = TILES * TILES * WIDTH_HEIGHT;
    localparam int ACC_AW   = 2*TILE_W + DIM_W;
    localparam int MEM_ROWS = 1 << ADDR_W;

    state_t              state_reg, state_next;
    logic [2:0]          op_reg;
    logic [DIM_W-1:0]    dim1_reg, dim2_reg, dim3_reg, cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [TILE_W-1:0]   trow_reg, tcol_reg;
    logic                done_reg, fifo_ready_reg;
    logic [ROW_W-1:0]    rd_data_reg;
    logic [ACC_ROWS-1:0] valid_reg;

    logic [ROW_W-1:0] input_mem  [MEM_ROWS];
    logic [ROW_W-1:0] weight_mem [MEM_ROWS];
    logic [ROW_W-1:0] acc_mem    [ACC_ROWS];
    logic [ROW_W-1:0] wreg       [WIDTH_HEIGHT];

    logic                            launch, busy_act, last_cycle;
    logic [ADDR_W-1:0]               row_addr;
    logic [ACC_AW-1:0]               acc_addr, rd_addr;
    logic [WIDTH_HEIGHT*ROW_W-1:0]   weights_flat;
    logic [ROW_W-1:0]                mac_y, acc_old, acc_new;

    assign launch     = reset && (state_reg == IDLE) && start;
    assign busy_act   = reset && (state_reg == BUSY);
    assign last_cycle = (cnt_reg == dim1_reg);
    assign row_addr   = addr_reg + ADDR_W'(cnt_reg);
    assign acc_addr   = {trow_reg, tcol_reg, cnt_reg};
    assign rd_addr    = {trow_reg, tcol_reg, addr_reg[DIM_W-1:0] + cnt_reg};

    assign done              = done_reg;
    assign fifo_ready        = fifo_ready_reg;
    assign outputMem_rd_data = rd_data_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = is_streaming(opcode) ? BUSY : DONE;
            BUSY:    if (last_cycle) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            done_reg       <= 1'b0;
            fifo_ready_reg <= 1'b0;
            rd_data_reg    <= '0;
            valid_reg      <= '0;
            op_reg         <= '0;
            dim1_reg       <= '0;
            dim2_reg       <= '0;
            dim3_reg       <= '0;
            addr_reg       <= '0;
            trow_reg       <= '0;
            tcol_reg       <= '0;
            cnt_reg        <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == DONE);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg   <= opcode;
                        dim1_reg <= dim_1;
                        dim2_reg <= dim_2;
                        dim3_reg <= dim_3;
                        addr_reg <= addr_1;
                        trow_reg <= accum_table_submat_row_in;
                        tcol_reg <= accum_table_submat_col_in;
                        cnt_reg  <= '0;
                        if (opcode == OP_LOAD_W) fifo_ready_reg <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (op_reg == OP_MATMUL) valid_reg[acc_addr] <= 1'b1;
                    if (op_reg == OP_RD_OUT)
                        rd_data_reg <= valid_reg[rd_addr] ? acc_mem[rd_addr] : '0;
                end
                DONE: begin
                    if (op_reg == OP_CLEAR) begin
                        fifo_ready_reg <= 1'b0;
                        valid_reg      <= '0;
                    end
                    if (op_reg == OP_LOAD_W) fifo_ready_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (busy_act && op_reg == OP_WR_IN) input_mem[row_addr] <= inputMem_wr_data;
    end

    always_ff @(posedge clk) begin
        if (busy_act && op_reg == OP_WR_W) weight_mem[row_addr] <= weightMem_wr_data;
    end

    always_ff @(posedge clk) begin
        if (busy_act && op_reg == OP_MATMUL) acc_mem[acc_addr] <= acc_new;
    end

    // Rows not reached by a short LOAD_W must read as zero, so the whole tile is cleared on launch.
    always_ff @(posedge clk) begin
        for (int r = 0; r < WIDTH_HEIGHT; r++) begin
            if (launch && opcode == OP_LOAD_W)
                wreg[r] <= '0;
            else if (busy_act && op_reg == OP_LOAD_W && cnt_reg == DIM_W'(r))
                wreg[r] <= weight_mem[row_addr];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH_HEIGHT; gi++) begin : g_wflat
            assign weights_flat[gi*ROW_W +: ROW_W] = fifo_ready_reg ? wreg[gi] : '0;
        end
        for (gi = 0; gi < WIDTH_HEIGHT; gi++) begin : g_acc
            assign acc_new[gi*DATA_WIDTH +: DATA_WIDTH] = acc_old[gi*DATA_WIDTH +: DATA_WIDTH] +
                                                          mac_y[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign acc_old = valid_reg[acc_addr] ? acc_mem[acc_addr] : '0;

    tpu_mac_row #(
        .WIDTH_HEIGHT (WIDTH_HEIGHT),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_mac_row (
        .x_row   (input_mem[row_addr]),
        .weights (weights_flat),
        .dim_2   (dim2_reg),
        .dim_3   (dim3_reg),
        .y_row   (mac_y)
    );

endmodule

// File: tb/tb_tpu_top.sv
// Directed self-checking bench for tpu_top: command sequencing, tiled matmul, accumulation and wrap cases.
module tb_tpu_top;
    import tpu_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   opcode;
    logic [3:0]   dim_1, dim_2, dim_3;
    logic [7:0]   addr_1;
    logic [2:0]   tile_row, tile_col;
    logic         done, fifo_ready;
    logic [127:0] in_wr, w_wr, rd_data;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    logic [127:0] exp_rows [16];
    logic         seen_done;

    always #5 clk = ~clk;

    tpu_top dut (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start),
        .opcode                    (opcode),
        .dim_1                     (dim_1),
        .dim_2                     (dim_2),
        .dim_3                     (dim_3),
        .addr_1                    (addr_1),
        .accum_table_submat_row_in (tile_row),
        .accum_table_submat_col_in (tile_col),
        .done                      (done),
        .fifo_ready                (fifo_ready),
        .inputMem_wr_data          (in_wr),
        .weightMem_wr_data         (w_wr),
        .outputMem_rd_data         (rd_data)
    );

    function automatic logic [127:0] rep(input logic [7:0] v);
        return {16{v}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the start edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] d1, input logic [3:0] d2,
                         input logic [3:0] d3, input logic [7:0] a, input logic [2:0] tr,
                         input logic [2:0] tc);
        opcode = op; dim_1 = d1; dim_2 = d2; dim_3 = d3; addr_1 = a;
        tile_row = tr; tile_col = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("cmd op=%b dim=%h/%h/%h addr=%h tile=(%0d,%0d)", op, d1, d2, d3, a, tr, tc);
    endtask

    // Entered just after the final cycle's edge: done must pulse exactly on the next edge.
    task automatic finish_cmd(input string tag);
        chk({tag, "_pre"}, done, 1'b0);
        @(negedge clk);
        chk({tag, "_done"}, done, 1'b1);
        @(negedge clk);
        chk({tag, "_after"}, done, 1'b0);
    endtask

    task automatic write_rows(input logic [2:0] op, input logic [7:0] a, input string tag);
        issue(op, 4'hF, 4'h0, 4'h0, a, 3'd0, 3'd0);
        for (int k = 1; k <= 16; k++) begin
            if (op == OP_WR_IN) in_wr = rep(8'(k));
            else                w_wr  = rep(8'(k));
            @(negedge clk);
        end
        finish_cmd(tag);
    endtask

    task automatic load_w(input logic [7:0] a, input string tag);
        issue(OP_LOAD_W, 4'hF, 4'h0, 4'h0, a, 3'd0, 3'd0);
        repeat (16) @(negedge clk);
        chk({tag, "_fifo_pre"}, fifo_ready, 1'b0);
        finish_cmd(tag);
        chk({tag, "_fifo"}, fifo_ready, 1'b1);
    endtask

    task automatic matmul(input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                          input logic [7:0] a, input logic [2:0] tr, input logic [2:0] tc,
                          input string tag);
        issue(OP_MATMUL, d1, d2, d3, a, tr, tc);
        repeat (int'(d1) + 1) @(negedge clk);
        finish_cmd(tag);
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [3:0] d1,
                            input logic [2:0] tr, input logic [2:0] tc, input logic [127:0] exp [16]);
        issue(OP_RD_OUT, d1, 4'h0, 4'h0, a, tr, tc);
        for (int k = 0; k <= int'(d1); k++) begin
            @(negedge clk);
            chk($sformatf("%s_row%0d", tag, k + 1), rd_data, exp[k]);
        end
        finish_cmd(tag);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; opcode = '0; dim_1 = '0; dim_2 = '0; dim_3 = '0;
        addr_1 = '0; tile_row = '0; tile_col = '0; in_wr = '0; w_wr = '0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_done", done, 1'b0);
        chk("rst_fifo", fifo_ready, 1'b0);
        chk("rst_rd", rd_data, '0);

        issue(OP_CLEAR, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0, 3'd0);
        finish_cmd("clear0");
        issue(3'b000, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0, 3'd0);
        finish_cmd("nop");

        write_rows(OP_WR_IN, 8'h40, "wr_in");
        write_rows(OP_WR_W, 8'h68, "wr_w");
        load_w(8'h68, "load_w");

        // Row r of In x W: r * sum(1..16) = r*136, wrapped to 8 bits.
        matmul(4'hF, 4'hF, 4'hF, 8'h40, 3'd2, 3'd2, "mm1");
        for (int k = 1; k <= 16; k++) exp_rows[k-1] = rep(8'(k * 136));
        rd_check("rd1", 8'h00, 4'hF, 3'd2, 3'd2, exp_rows);

        matmul(4'hF, 4'hF, 4'hF, 8'h40, 3'd2, 3'd2, "mm2");
        exp_rows[0] = rep(8'h10);
        exp_rows[1] = rep(8'h20);
        rd_check("rd2", 8'h00, 4'h1, 3'd2, 3'd2, exp_rows);

        // x = all 1s, only weight rows 0..1 and columns 0..3 active: 1*1 + 1*2 = 3.
        matmul(4'h0, 4'h1, 4'h3, 8'h40, 3'd1, 3'd1, "mm_mask");
        exp_rows[0] = 128'h03030303;
        rd_check("rd_mask", 8'h00, 4'h0, 3'd1, 3'd1, exp_rows);

        issue(OP_CLEAR, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0, 3'd0);
        finish_cmd("clear1");
        chk("clear1_fifo", fifo_ready, 1'b0);
        exp_rows[0] = '0;
        rd_check("rd_clr", 8'h00, 4'h0, 3'd2, 3'd2, exp_rows);

        load_w(8'h68, "load_w2");
        // Writes land at F8..FF then 00..07: 0xFF holds 8, 0x00 holds 9, 0x07 holds 16.
        write_rows(OP_WR_IN, 8'hF8, "wr_wrap");
        matmul(4'h1, 4'hF, 4'hF, 8'hFF, 3'd3, 3'd3, "mm_wrap");
        exp_rows[0] = rep(8'h40);
        exp_rows[1] = rep(8'hC8);
        rd_check("rd_wrap", 8'h00, 4'h1, 3'd3, 3'd3, exp_rows);
        exp_rows[0] = '0;
        exp_rows[1] = rep(8'h40);
        rd_check("rd_wrap_idx", 8'h0F, 4'h1, 3'd3, 3'd3, exp_rows);
        matmul(4'h0, 4'hF, 4'hF, 8'h07, 3'd3, 3'd4, "mm_07");
        exp_rows[0] = rep(8'h80);
        rd_check("rd_07", 8'h00, 4'h0, 3'd3, 3'd4, exp_rows);

        // A CLEAR strobe while busy must not be taken.
        issue(OP_WR_IN, 4'h3, 4'h0, 4'h0, 8'h80, 3'd0, 3'd0);
        for (int k = 1; k <= 4; k++) begin
            in_wr = rep(8'(k));
            if (k == 2) begin
                start  = 1'b1;
                opcode = OP_CLEAR;
            end
            @(negedge clk);
            start = 1'b0;
        end
        finish_cmd("busy_start");
        chk("busy_start_fifo", fifo_ready, 1'b1);

        issue(OP_WR_IN, 4'hF, 4'h0, 4'h0, 8'h90, 3'd0, 3'd0);
        for (int k = 1; k <= 3; k++) begin
            in_wr = rep(8'(k));
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        $display("reset asserted mid WR_IN");
        chk("midrst_done", done, 1'b0);
        chk("midrst_fifo", fifo_ready, 1'b0);
        chk("midrst_rd", rd_data, '0);
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        chk("midrst_no_done", seen_done, 1'b0);
        issue(OP_CLEAR, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0, 3'd0);
        finish_cmd("post_rst_clear");
        exp_rows[0] = '0;
        rd_check("rd_post_rst", 8'h00, 4'h0, 3'd3, 3'd3, exp_rows);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
